// File: rtl/fetch_pkg.sv
// Shared fetch-path types and sizing constants for the instruction queue.
// Supplies default PC/instruction widths when the including build has not set them.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

package fetch_pkg;

    localparam int FetchQDepth = 8;
    localparam int FetchQPtrW  = $clog2(FetchQDepth);
    localparam int FetchQCntW  = FetchQPtrW + 1;

    typedef struct packed {
        logic [`AddrWidth-1:0] pc;
        logic [`InstWidth-1:0] inst;
    } FetchQEntry_t;

endpackage

// File: rtl/fetch_inst_queue.sv
// In-order (PC, instruction) queue decoupling fetch from decode, with single-cycle flush.
// Optional FETCH_QUEUE_BYPASS_EN forwards input straight to output when the queue is empty.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

module fetch_inst_queue
    import fetch_pkg::*;
#(
    parameter int ADDR  = `AddrWidth,
    parameter int INST  = `InstWidth,
    parameter int DEPTH = FetchQDepth
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [ADDR-1:0]          in_pc,
    input  logic [INST-1:0]          in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [ADDR-1:0]          out_pc,
    output logic [INST-1:0]          out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR-1:0] pc;
        logic [INST-1:0] inst;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             bypass;
    logic             push;
    logic             pop;

    // Handshake: a transfer happens on an edge where valid && ready are both high;
    // in_ready depends only on occupancy, never on out_ready, and flush cancels both sides.
    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready && !flush && !bypass;
    assign pop      = (count != '0) && out_ready && !flush && !bypass;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass    = (count == '0) && in_valid && out_ready && !flush;
    assign out_valid = (count != '0) || bypass;
    assign out_pc    = bypass ? in_pc   : mem[head].pc;
    assign out_inst  = bypass ? in_inst : mem[head].inst;
`else
    assign bypass    = 1'b0;
    assign out_valid = (count != '0);
    assign out_pc    = mem[head].pc;
    assign out_inst  = mem[head].inst;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage is deliberately not reset; out_* are meaningless while out_valid is low.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail].pc   <= in_pc;
            mem[tail].inst <= in_inst;
        end
    end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed self-checking bench for fetch_inst_queue; expected PCs come from an in-bench queue.
// Covers reset, ordering, full refusal, wrap, flush, async reset and the bypass option.
`timescale 1ns/1ps

module tb_fetch_inst_queue;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_pc;
    logic [W-1:0] in_inst;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_pc;
    logic [W-1:0] out_inst;
    logic         out_ready;
    logic [3:0]   count;

    logic [W-1:0] exp_q[$];
    int           errors = 0;
    int           checks = 0;

    fetch_inst_queue #(.ADDR(W), .INST(W), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
        .count(count)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [W-1:0] inst_of(input logic [W-1:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: one push cycle with out_ready low
    task automatic push_one(input logic [W-1:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst_of(pc);
        tick();
        in_valid = 1'b0;
        exp_q.push_back(pc);
    endtask

    // scoreboard: pop one head entry and compare against the expected queue
    task automatic pop_expect(input string tag);
        logic [W-1:0] exp_pc;
        exp_pc    = exp_q.pop_front();
        out_ready = 1'b1;
        #1;
        check({tag, "_valid"}, W'(out_valid), W'(1));
        check({tag, "_pc"}, out_pc, exp_pc);
        check({tag, "_inst"}, out_inst, inst_of(exp_pc));
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
        #23;
        reset = 1'b0;
        tick();
        check("rst_count", W'(count), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));

        // three pushes then ordered pops
        push_one(32'h100);
        push_one(32'h104);
        push_one(32'h108);
        check("three_count", W'(count), W'(3));
        for (int i = 0; i < 3; i++) pop_expect("order");
        check("order_empty_valid", W'(out_valid), W'(0));
        check("order_empty_count", W'(count), W'(0));

        // fill to full, then a refused push while popping
        for (int i = 0; i < 8; i++) begin
            check("fill_in_ready", W'(in_ready), W'(1));
            push_one(32'h500 + 32'(4 * i));
        end
        check("full_count", W'(count), W'(8));
        check("full_in_ready", W'(in_ready), W'(0));
        in_valid  = 1'b1;
        in_pc     = 32'h200;
        in_inst   = inst_of(32'h200);
        out_ready = 1'b1;
        #1;
        check("full_pop_in_ready", W'(in_ready), W'(0));
        check("full_pop_pc", out_pc, exp_q.pop_front());
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("refused_count", W'(count), W'(7));
        for (int i = 0; i < 7; i++) pop_expect("drain");
        check("drain_empty", W'(out_valid), W'(0));

        // sustained push+pop across pointer wrap
        in_valid = 1'b1;
        in_pc    = 32'h0;
        in_inst  = inst_of(32'h0);
        tick();
        for (int i = 1; i < 20; i++) begin
            in_pc     = 32'(4 * i);
            in_inst   = inst_of(32'(4 * i));
            out_ready = 1'b1;
            #1;
            check("stream_valid", W'(out_valid), W'(1));
            check("stream_pc", out_pc, 32'(4 * (i - 1)));
            check("stream_inst", out_inst, inst_of(32'(4 * (i - 1))));
            tick();
            check("stream_count", W'(count), W'(1));
        end
        in_valid = 1'b0;
        #1;
        check("stream_last_pc", out_pc, 32'h4C);
        tick();
        out_ready = 1'b0;
        check("stream_end_count", W'(count), W'(0));

        // flush with a concurrent push
        for (int i = 0; i < 5; i++) push_one(32'h600 + 32'(4 * i));
        check("preflush_count", W'(count), W'(5));
        exp_q.delete();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h300;
        in_inst  = inst_of(32'h300);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", W'(count), W'(0));
        check("flush_valid", W'(out_valid), W'(0));
        push_one(32'h700);
        pop_expect("post_flush");
        check("post_flush_count", W'(count), W'(0));

        // asynchronous reset between edges
        push_one(32'h800);
        push_one(32'h804);
        push_one(32'h808);
        check("prereset_count", W'(count), W'(3));
        #2 reset = 1'b1;
        #1;
        check("async_count", W'(count), W'(0));
        check("async_valid", W'(out_valid), W'(0));
        check("async_in_ready", W'(in_ready), W'(1));
        #1 reset = 1'b0;
        exp_q.delete();
        tick();

        // empty queue, in_valid and out_ready together
        in_valid  = 1'b1;
        in_pc     = 32'h400;
        in_inst   = inst_of(32'h400);
        out_ready = 1'b1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_valid", W'(out_valid), W'(1));
        check("byp_pc", out_pc, 32'h400);
        check("byp_inst", out_inst, inst_of(32'h400));
        tick();
        in_valid = 1'b0;
        check("byp_count", W'(count), W'(0));
        #1;
        check("byp_after_valid", W'(out_valid), W'(0));
`else
        check("nobyp_valid", W'(out_valid), W'(0));
        tick();
        in_valid = 1'b0;
        check("nobyp_count", W'(count), W'(1));
        #1;
        check("nobyp_next_valid", W'(out_valid), W'(1));
        check("nobyp_next_pc", out_pc, 32'h400);
        tick();
        check("nobyp_end_count", W'(count), W'(0));
`endif
        out_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_inst_queue.md
# fetch_inst_queue

Decoupling instruction queue between `fetch_top` and the decode stage. It captures each fetched (PC, instruction) pair with a valid/ready handshake and buffers up to DEPTH entries in order. It presents them to decode and absorbs decode stalls without back-pressuring the I-cache path. A single-cycle flush (branch mispredict / exception redirect) discards all buffered entries.

## Interface
Parameters:
- `ADDR`, default `` `AddrWidth ``: PC width.
- `INST`, default `` `InstWidth ``: instruction width.
- `DEPTH`, default 8: entry count; power of two, ≥ 2.

Ports:
- `clk`  in  1  : clock; all state updates on the rising edge.
- `reset`  in  1  : reset, asynchronous, active-high.
- `flush`  in  1  : synchronous discard of all entries.
- `in_valid`  in  1  : fetch presents an entry.
- `in_pc`  in  ADDR  : PC of the presented instruction.
- `in_inst`  in  INST  : instruction word.
- `in_ready`  out  1  : queue accepts an entry this cycle.
- `out_valid`  out  1  : head entry valid for decode.
- `out_pc`  out  ADDR  : head PC.
- `out_inst`  out  INST  : head instruction.
- `out_ready`  in  1  : decode consumes the head this cycle.
- `count`  out  $clog2(DEPTH)+1  : current occupancy.

## Operation
- Storage: DEPTH-entry flop array. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. An occupancy counter tracks the fill level.
- Push: `in_valid && in_ready && !flush`. The entry is written at tail, and tail increments.
- Pop: `out_valid && out_ready && !flush`. Head increments.
- `in_ready = (count != DEPTH)`. This signal is independent of `out_ready`, so a full queue with a simultaneous pop still refuses the push.
- `out_valid = (count != 0)`. `out_pc`/`out_inst` are a combinational read of the array at head.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Flush: on the next edge, head, tail and count return to 0. A push or pop in the flush cycle is ignored.
- Data outputs are don't-care when `out_valid` is 0. The bench must not check them.

## Timing
- Reset values: `count`=0, `in_ready`=1, `out_valid`=0; head and tail = 0. `out_pc`/`out_inst` read entry 0; the array is not reset.
- Reset asserted mid-operation: all state clears immediately (asynchronous), regardless of `clk`.
- Latency, macro off: an entry pushed at edge N is visible on `out_valid` after edge N, i.e. in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- `count` is registered and always equals pushes minus pops since the last reset or flush.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When `count==0 && in_valid && out_ready && !flush`, the input is forwarded combinationally: `out_valid`=1, `out_pc=in_pc`, `out_inst=in_inst`.
  - Nothing is stored and count stays 0.
  - With `count==0 && in_valid && !out_ready`, the entry is stored normally.
- Undefined: no combinational path from `in_*` to `out_*`; minimum latency is one cycle.

## Structure
- Shared package `fetch_pkg`:
  - typedef `FetchQEntry_t` (packed struct {pc, inst}).
  - localparam `FetchQDepth` = 8.
  - Pointer and count width constants derived via $clog2.
- No sub-module. Storage and pointer logic stay inline; the queue is a single module.

## Test plan
- Reset, then idle: `count`=0, `in_ready`=1, `out_valid`=0. Assert `reset` between edges with count=3: `count` drops to 0 without a clock edge.
- Push PC 0x100/0x104/0x108 with `out_ready`=0: `count`=3. Then `out_ready`=1: three pops in order 0x100, 0x104, 0x108; then `out_valid`=0.
- Fill 8 entries with `out_ready`=0: `in_ready`=0 at count 8. A push attempt of 0x200 with `out_ready`=1 is refused: count 7, and 0x200 is never output.
- Continuous push/pop for 20 cycles, PCs 0x0 to 0x4C in steps of 4: count holds at 1. Output order is exact across pointer wrap (wraps twice).
- count=5, `flush` with `in_valid`=1 (PC 0x300): the next cycle has `count`=0 and `out_valid`=0, and 0x300 is never output.
- Bypass, macro defined: empty queue, `in_valid`=`out_ready`=1, PC 0x400: same-cycle `out_valid`=1, `out_pc`=0x400, and `count` stays 0. Macro undefined: `out_valid` is first asserted the following cycle.
